// File: rtl/psr_pkg.sv
// Shared definitions for the PSR / window unit: PSR bit positions, trap
// type codes, reset values and the control FSM state type.
package psr_pkg;

    localparam int PSR_W = 12;
    localparam int WIM_W = 4;
    localparam int TT_W  = 8;

    localparam int PSR_N      = 11;
    localparam int PSR_Z      = 10;
    localparam int PSR_V      = 9;
    localparam int PSR_C      = 8;
    localparam int PSR_S      = 7;
    localparam int PSR_PS     = 6;
    localparam int PSR_ET     = 5;
    localparam int PSR_CWP_HI = 1;
    localparam int PSR_CWP_LO = 0;

    localparam logic [PSR_W-1:0] PSR_RESET   = 12'h0A0;
    // Reserved bits [4:2] are forced to zero on every software write.
    localparam logic [PSR_W-1:0] PSR_WR_MASK = 12'hFE3;
    localparam logic [WIM_W-1:0] WIM_RESET   = 4'b0010;

    localparam logic [TT_W-1:0] TT_ILLEGAL   = 8'h02;
    localparam logic [TT_W-1:0] TT_PRIV      = 8'h03;
    localparam logic [TT_W-1:0] TT_OVERFLOW  = 8'h05;
    localparam logic [TT_W-1:0] TT_UNDERFLOW = 8'h06;
    localparam logic [TT_W-1:0] TT_TICC_BASE = 8'h80;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_ERROR = 1'b1
    } psr_state_t;

    function automatic logic [TT_W-1:0] ticc_tt(input logic [6:0] num);
        return TT_TICC_BASE | {1'b0, num};
    endfunction

endpackage

// File: rtl/window_check.sv
// Combinational window neighbour calculation: CWP-1 / CWP+1 modulo 4 and
// whether the invalid-window mask marks either neighbour.
module window_check
    import psr_pkg::*;
(
    input  logic [1:0]       cwp,
    input  logic [WIM_W-1:0] wim,
    output logic [1:0]       cwp_dec,
    output logic [1:0]       cwp_inc,
    output logic             hit_dec,
    output logic             hit_inc
);

    // Two-bit arithmetic wraps naturally: 0-1 -> 3, 3+1 -> 0.
    assign cwp_dec = cwp - 2'd1;
    assign cwp_inc = cwp + 2'd1;
    assign hit_dec = wim[cwp_dec];
    assign hit_inc = wim[cwp_inc];

endmodule

// File: rtl/psr_window_unit.sv
// Processor state register with register-window control, trap entry,
// return-from-trap handling and a sticky error mode.
module psr_window_unit
    import psr_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_c,
    input  logic             icc_we,
    input  logic             save_req,
    input  logic             restore_req,
    input  logic             rett_req,
    input  logic             tcond,
    input  logic [6:0]       ticc_num,
    input  logic             wrpsr_we,
    input  logic [PSR_W-1:0] wr_data,
    input  logic             wrwim_we,
    input  logic [WIM_W-1:0] wim_data,
    output logic [PSR_W-1:0] psr,
    output logic [WIM_W-1:0] wim,
    output logic             N,
    output logic             Z,
    output logic             V,
    output logic             C,
    output logic             trap_taken,
    output logic [TT_W-1:0]  tt,
    output logic             error_mode
);

    psr_state_t       state_q, state_d;
    logic [PSR_W-1:0] psr_q, psr_d;
    logic [WIM_W-1:0] wim_q, wim_d;
    logic [TT_W-1:0]  tt_q, tt_d;
    logic             trap_q, trap_d;

    logic [1:0]       cwp_dec, cwp_inc;
    logic             hit_dec, hit_inc;
    logic             trap_req;
    logic [TT_W-1:0]  trap_code;
    logic             cur_s, cur_ps, cur_et;

    assign cur_s  = psr_q[PSR_S];
    assign cur_ps = psr_q[PSR_PS];
    assign cur_et = psr_q[PSR_ET];

    window_check u_window_check (
        .cwp     (psr_q[PSR_CWP_HI:PSR_CWP_LO]),
        .wim     (wim_q),
        .cwp_dec (cwp_dec),
        .cwp_inc (cwp_inc),
        .hit_dec (hit_dec),
        .hit_inc (hit_inc)
    );

    // Trap detection: the first matching cause in this chain supplies tt.
    always_comb begin
        trap_req  = 1'b0;
        trap_code = '0;
        if (tcond) begin
            trap_req  = 1'b1;
            trap_code = ticc_tt(ticc_num);
        end else if (save_req && restore_req) begin
            trap_req  = 1'b1;
            trap_code = TT_ILLEGAL;
        end else if (rett_req) begin
            if (cur_et) begin
                trap_req  = 1'b1;
                trap_code = TT_ILLEGAL;
            end else if (!cur_s) begin
                trap_req  = 1'b1;
                trap_code = TT_PRIV;
            end else if (hit_inc) begin
                trap_req  = 1'b1;
                trap_code = TT_UNDERFLOW;
            end
        end else if (save_req && hit_dec) begin
            trap_req  = 1'b1;
            trap_code = TT_OVERFLOW;
        end else if (restore_req && hit_inc) begin
            trap_req  = 1'b1;
            trap_code = TT_UNDERFLOW;
        end
    end

    // Next-state / next-register logic; ERROR holds every register.
    always_comb begin
        state_d = state_q;
        psr_d   = psr_q;
        wim_d   = wim_q;
        tt_d    = tt_q;
        trap_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (wrwim_we) begin
                    wim_d = wim_data;
                end
                if (trap_req) begin
                    if (cur_et) begin
                        psr_d[PSR_ET]                = 1'b0;
                        psr_d[PSR_PS]                = cur_s;
                        psr_d[PSR_S]                 = 1'b1;
                        psr_d[PSR_CWP_HI:PSR_CWP_LO] = cwp_dec;
                        tt_d                         = trap_code;
                        trap_d                       = 1'b1;
                    end else begin
                        // A trap with traps disabled is unrecoverable.
                        state_d = ST_ERROR;
                        psr_d   = psr_q;
                        wim_d   = wim_q;
                    end
                end else if (rett_req) begin
                    psr_d[PSR_ET]                = 1'b1;
                    psr_d[PSR_S]                 = cur_ps;
                    psr_d[PSR_CWP_HI:PSR_CWP_LO] = cwp_inc;
                end else if (wrpsr_we) begin
                    psr_d = wr_data & PSR_WR_MASK;
                end else if (save_req) begin
                    psr_d[PSR_CWP_HI:PSR_CWP_LO] = cwp_dec;
                end else if (restore_req) begin
                    psr_d[PSR_CWP_HI:PSR_CWP_LO] = cwp_inc;
                end else if (icc_we) begin
                    psr_d[PSR_N:PSR_C] = {alu_n, alu_z, alu_v, alu_c};
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            psr_q   <= PSR_RESET;
            wim_q   <= WIM_RESET;
            tt_q    <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            psr_q   <= psr_d;
            wim_q   <= wim_d;
            tt_q    <= tt_d;
            trap_q  <= trap_d;
        end
    end

    assign psr        = psr_q;
    assign wim        = wim_q;
    assign N          = psr_q[PSR_N];
    assign Z          = psr_q[PSR_Z];
    assign V          = psr_q[PSR_V];
    assign C          = psr_q[PSR_C];
    assign tt         = tt_q;
    assign trap_taken = trap_q;
    assign error_mode = (state_q == ST_ERROR);

endmodule

// File: tb/tb_psr_window_unit.sv
// Directed bench for psr_window_unit: each step pushes its expected output
// word to a queue, which is popped and compared one cycle later.
module tb_psr_window_unit;

    localparam int EW = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_n, alu_z, alu_v, alu_c, icc_we;
    logic        save_req, restore_req, rett_req, tcond;
    logic [6:0]  ticc_num;
    logic        wrpsr_we, wrwim_we;
    logic [11:0] wr_data;
    logic [3:0]  wim_data;
    logic [11:0] psr;
    logic [3:0]  wim;
    logic        N, Z, V, C, trap_taken, error_mode;
    logic [7:0]  tt;

    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad = 0;

    psr_window_unit dut (
        .clk(clk), .reset(reset),
        .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
        .icc_we(icc_we), .save_req(save_req), .restore_req(restore_req),
        .rett_req(rett_req), .tcond(tcond), .ticc_num(ticc_num),
        .wrpsr_we(wrpsr_we), .wr_data(wr_data),
        .wrwim_we(wrwim_we), .wim_data(wim_data),
        .psr(psr), .wim(wim), .N(N), .Z(Z), .V(V), .C(C),
        .trap_taken(trap_taken), .tt(tt), .error_mode(error_mode)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    function automatic logic [11:0] mkpsr(input logic [3:0] icc, input logic s,
                                          input logic ps, input logic et,
                                          input logic [1:0] cwp);
        return {icc, s, ps, et, 3'b000, cwp};
    endfunction

    function automatic logic [EW-1:0] mkexp(input logic em, input logic tp,
                                            input logic [7:0] t, input logic [3:0] w,
                                            input logic [11:0] p);
        return {em, tp, t, w, p[11:8], p};
    endfunction

    // Driver tasks
    task automatic clear_inputs();
        {alu_n, alu_z, alu_v, alu_c, icc_we} = '0;
        {save_req, restore_req, rett_req, tcond} = '0;
        ticc_num = '0;
        wrpsr_we = 1'b0;
        wr_data  = '0;
        wrwim_we = 1'b0;
        wim_data = '0;
    endtask

    task automatic push_exp(input logic [EW-1:0] e);
        exp_q.push_back(e);
    endtask

    // Scoreboard compare against the oldest expected word
    task automatic check(input string tag);
        logic [EW-1:0] g, e;
        g = {error_mode, trap_taken, tt, wim, N, Z, V, C, psr};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, got %h", tag, g);
        end else begin
            e = exp_q.pop_front();
            assert (g === e) else begin
                bad++;
                $error("FAIL %s: got %h expected %h", tag, g, e);
            end
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        check(tag);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push_exp(mkexp(0, 0, 8'h00, 4'b0010, 12'h0A0));
        check("reset_state");
        reset = 1'b0;

        save_req = 1;
        push_exp(mkexp(0, 0, 8'h00, 4'b0010, mkpsr(4'h0, 1, 0, 1, 2'd3)));
        tick("save_wrap_0_to_3");

        save_req = 1;
        push_exp(mkexp(0, 0, 8'h00, 4'b0010, mkpsr(4'h0, 1, 0, 1, 2'd2)));
        tick("save_3_to_2");

        save_req = 1;
        push_exp(mkexp(0, 1, 8'h05, 4'b0010, mkpsr(4'h0, 1, 1, 0, 2'd1)));
        tick("save_overflow_trap");

        push_exp(mkexp(0, 0, 8'h05, 4'b0010, mkpsr(4'h0, 1, 1, 0, 2'd1)));
        tick("trap_pulse_end_tt_hold");

        wrwim_we = 1; wim_data = 4'b0000;
        push_exp(mkexp(0, 0, 8'h05, 4'b0000, mkpsr(4'h0, 1, 1, 0, 2'd1)));
        tick("wrwim_clear");

        rett_req = 1;
        push_exp(mkexp(0, 0, 8'h05, 4'b0000, mkpsr(4'h0, 1, 1, 1, 2'd2)));
        tick("rett_ok");

        rett_req = 1;
        push_exp(mkexp(0, 1, 8'h02, 4'b0000, mkpsr(4'h0, 1, 1, 0, 2'd1)));
        tick("rett_et1_trap");

        restore_req = 1;
        push_exp(mkexp(0, 0, 8'h02, 4'b0000, mkpsr(4'h0, 1, 1, 0, 2'd2)));
        tick("restore_1_to_2");

        wrpsr_we = 1; wr_data = 12'hFFF; save_req = 1;
        push_exp(mkexp(0, 0, 8'h02, 4'b0000, 12'hFE3));
        tick("wrpsr_masks_reserved_drops_save");

        wrpsr_we = 1; wr_data = 12'h0A0;
        icc_we = 1; {alu_n, alu_z, alu_v, alu_c} = 4'b1111;
        push_exp(mkexp(0, 0, 8'h02, 4'b0000, 12'h0A0));
        tick("wrpsr_beats_icc");

        icc_we = 1; {alu_n, alu_z, alu_v, alu_c} = 4'b1001;
        tcond = 1; ticc_num = 7'h10;
        push_exp(mkexp(0, 1, 8'h90, 4'b0000, mkpsr(4'h0, 1, 1, 0, 2'd3)));
        tick("ticc_trap_drops_icc");

        icc_we = 1; {alu_n, alu_z, alu_v, alu_c} = 4'b1001;
        push_exp(mkexp(0, 0, 8'h90, 4'b0000, mkpsr(4'h9, 1, 1, 0, 2'd3)));
        tick("icc_load");

        wrpsr_we = 1; wr_data = 12'h0A3; wrwim_we = 1; wim_data = 4'b0001;
        push_exp(mkexp(0, 0, 8'h90, 4'b0001, 12'h0A3));
        tick("wrpsr_with_wrwim");

        restore_req = 1;
        push_exp(mkexp(0, 1, 8'h06, 4'b0001, mkpsr(4'h0, 1, 1, 0, 2'd2)));
        tick("restore_underflow_wrap");

        wrpsr_we = 1; wr_data = 12'h0A1;
        push_exp(mkexp(0, 0, 8'h06, 4'b0001, 12'h0A1));
        tick("wrpsr_cwp1");

        save_req = 1; restore_req = 1;
        push_exp(mkexp(0, 1, 8'h02, 4'b0001, mkpsr(4'h0, 1, 1, 0, 2'd0)));
        tick("save_restore_together");

        wrpsr_we = 1; wr_data = 12'h080;
        push_exp(mkexp(0, 0, 8'h02, 4'b0001, 12'h080));
        tick("wrpsr_et0");

        tcond = 1; ticc_num = 7'h10;
        push_exp(mkexp(1, 0, 8'h02, 4'b0001, 12'h080));
        tick("trap_et0_error");

        save_req = 1; wrwim_we = 1; wim_data = 4'b1111;
        icc_we = 1; {alu_n, alu_z, alu_v, alu_c} = 4'b1111;
        push_exp(mkexp(1, 0, 8'h02, 4'b0001, 12'h080));
        tick("error_frozen");

        // Asynchronous reset between edges while a save is pending
        save_req = 1;
        #3;
        reset = 1'b1;
        #1;
        push_exp(mkexp(0, 0, 8'h00, 4'b0010, 12'h0A0));
        check("async_reset_immediate");
        @(posedge clk);
        #1;
        push_exp(mkexp(0, 0, 8'h00, 4'b0010, 12'h0A0));
        check("reset_held_over_save");
        reset = 1'b0;
        clear_inputs();

        save_req = 1;
        push_exp(mkexp(0, 0, 8'h00, 4'b0010, mkpsr(4'h0, 1, 0, 1, 2'd3)));
        tick("save_after_reset");

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
